// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC run controller.
//   state_e : controller state as seen on state_o (HALT/RUN/STEP)
//   cmd_e   : debug command opcodes carried on cmd_op
//   is_active() : true in the states where the datapath is allowed to advance
package kgp_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CMD_RUN  = 2'd0,
    CMD_HALT = 2'd1,
    CMD_STEP = 2'd2,
    CMD_CLR  = 2'd3
  } cmd_e;

  localparam int unsigned PcW = 32;

  function automatic logic is_active(state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/kgp_run_controller_if.sv
// Bundle of command, datapath-status and observation signals around the run controller.
//   master : debug host + datapath side (drives commands, PC, HALT decode, stall)
//   slave  : the controller (drives dp_ce, dp_pc_reset, state, bp_hit, counters)
interface kgp_run_controller_if #(
  parameter int unsigned CNT_W = 32
);
  import kgp_pkg::*;

  logic             cmd_valid;
  logic [1:0]       cmd_op;
  logic             cmd_ready;
  logic             bp_en;
  logic [PcW-1:0]   bp_addr;
  logic [PcW-1:0]   dp_pc;
  logic             dp_halt_insn;
  logic             mem_busy;
  logic             dp_ce;
  logic             dp_pc_reset;
  logic [1:0]       state_o;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output cmd_valid, cmd_op, bp_en, bp_addr, dp_pc, dp_halt_insn, mem_busy,
    input  cmd_ready, dp_ce, dp_pc_reset, state_o, bp_hit, cycle_cnt, retired_cnt
  );

  modport slave (
    input  cmd_valid, cmd_op, bp_en, bp_addr, dp_pc, dp_halt_insn, mem_busy,
    output cmd_ready, dp_ce, dp_pc_reset, state_o, bp_hit, cycle_cnt, retired_cnt
  );

endinterface

// File: rtl/kgp_event_counter.sv
// Wrapping event counter with synchronous clear.
//   clk, rst (async, active-low), inc (count this cycle), clr (zero next cycle, beats inc),
//   count (current value, wraps mod 2^CNT_W)
module kgp_event_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + One;
    end
  end

endmodule

// File: rtl/kgp_run_controller.sv
// Run/halt/single-step sequencer for the KGP-RISC single-cycle datapath.
//   clk, rst (async, active-low)
//   bus (slave): cmd_valid/cmd_op/cmd_ready debug command handshake; bp_en/bp_addr breakpoint;
//     dp_pc/dp_halt_insn/mem_busy datapath status; dp_ce datapath enable (combinational);
//     dp_pc_reset PC-clear pulse; state_o; bp_hit stop pulse; cycle_cnt/retired_cnt counters.
module kgp_run_controller
  import kgp_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          AUTO_RUN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  kgp_run_controller_if.slave  bus
);

  localparam state_e RstState = AUTO_RUN ? ST_RUN : ST_HALT;

  state_e state_q;
  logic   skip_bp_q;
  logic   bp_hit_q;
  logic   pc_reset_q;

  cmd_e   op;
  logic   running;
  logic   acc;
  logic   halt_cmd;
  logic   clr_cmd;
  logic   bp_stop;
  logic   dp_ce;

  assign op       = cmd_e'(bus.cmd_op);
  assign running  = is_active(state_q);
  assign acc      = bus.cmd_valid && (state_q != ST_STEP);
  assign halt_cmd = acc && (op == CMD_HALT);
  // CLR only has an effect while halted; in RUN it is accepted and ignored.
  assign clr_cmd  = acc && (op == CMD_CLR) && (state_q == ST_HALT);
  // skip_bp masks the breakpoint for the first instruction after a resume so that
  // execution can leave a breakpoint PC.
  assign bp_stop  = bus.bp_en && (bus.dp_pc == bus.bp_addr) && !skip_bp_q && running;
  assign dp_ce    = running && !bus.mem_busy && !bp_stop && !halt_cmd;

  assign bus.cmd_ready   = (state_q != ST_STEP);
  assign bus.dp_ce       = dp_ce;
  assign bus.dp_pc_reset = pc_reset_q;
  assign bus.state_o     = state_q;
  assign bus.bp_hit      = bp_hit_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RstState;
      skip_bp_q  <= 1'b0;
      bp_hit_q   <= 1'b0;
      pc_reset_q <= 1'b0;
    end else begin
      bp_hit_q   <= 1'b0;
      pc_reset_q <= 1'b0;
      // dp_ce is never high in HALT, so this cannot collide with the set below.
      if (dp_ce) begin
        skip_bp_q <= 1'b0;
      end
      unique case (state_q)
        ST_HALT: begin
          if (acc) begin
            case (op)
              CMD_RUN: begin
                state_q   <= ST_RUN;
                skip_bp_q <= 1'b1;
              end
              CMD_STEP: begin
                state_q   <= ST_STEP;
                skip_bp_q <= 1'b1;
              end
              CMD_CLR:  pc_reset_q <= 1'b1;
              default:  ;
            endcase
          end
        end
        ST_RUN: begin
          // Priority: HALT command, breakpoint, HALT instruction; stalls simply hold.
          if (halt_cmd) begin
            state_q <= ST_HALT;
          end else if (bp_stop) begin
            state_q  <= ST_HALT;
            bp_hit_q <= 1'b1;
          end else if (dp_ce && bus.dp_halt_insn) begin
            state_q <= ST_HALT;
          end
        end
        ST_STEP: begin
          if (bp_stop) begin
            state_q  <= ST_HALT;
            bp_hit_q <= 1'b1;
          end else if (dp_ce) begin
            state_q <= ST_HALT;
          end
        end
        default: state_q <= RstState;
      endcase
    end
  end

  kgp_event_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (running),
    .clr   (clr_cmd),
    .count (bus.cycle_cnt)
  );

  kgp_event_counter #(
    .CNT_W (CNT_W)
  ) u_retired_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (dp_ce),
    .clr   (clr_cmd),
    .count (bus.retired_cnt)
  );

endmodule

// File: tb/tb_kgp_run_controller.sv
// Bench for kgp_run_controller: a behavioural model checked every cycle plus directed
// scenarios with hand-computed literal expectations.
module tb_kgp_run_controller;

  localparam int unsigned CNT_W = 32;

  logic clk;
  logic rst;
  kgp_run_controller_if #(.CNT_W(CNT_W)) bus ();

  kgp_run_controller #(
    .CNT_W    (CNT_W),
    .AUTO_RUN (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 halted, 1 running, 2 single-stepping
  int               m_mode;
  bit               m_skip;
  bit               m_bp_hit;
  bit               m_pcr;
  logic [CNT_W-1:0] m_cyc;
  logic [CNT_W-1:0] m_ret;

  function automatic bit m_ready();
    return m_mode != 2;
  endfunction

  function automatic bit m_halt_req();
    return bus.cmd_valid && m_ready() && bus.cmd_op == 2'd1;
  endfunction

  function automatic bit m_bp();
    return bus.bp_en && bus.dp_pc == bus.bp_addr && !m_skip && m_mode != 0;
  endfunction

  // An instruction retires when executing, not stalled, not at a live breakpoint,
  // and not being halted by the host this cycle.
  function automatic bit m_ce();
    return m_mode != 0 && !bus.mem_busy && !m_bp() && !m_halt_req();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 1; m_skip = 0; m_bp_hit = 0; m_pcr = 0; m_cyc = '0; m_ret = '0;
    end else begin
      automatic bit ce  = m_ce();
      automatic bit bp  = m_bp();
      automatic bit hr  = m_halt_req();
      automatic int nxt = m_mode;
      m_bp_hit = 0;
      m_pcr    = 0;
      if (m_mode != 0) m_cyc = m_cyc + 1;
      if (ce) begin
        m_ret  = m_ret + 1;
        m_skip = 0;
      end
      if (m_mode == 0) begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op == 2'd0) begin nxt = 1; m_skip = 1; end
          if (bus.cmd_op == 2'd2) begin nxt = 2; m_skip = 1; end
          if (bus.cmd_op == 2'd3) begin m_pcr = 1; m_cyc = '0; m_ret = '0; end
        end
      end else if (hr || bp) begin
        nxt = 0;
        m_bp_hit = !hr;
      end else if (ce && (m_mode == 2 || bus.dp_halt_insn)) begin
        nxt = 0;
      end
      m_mode = nxt;
    end
  end

  always @(negedge clk) begin
    if (rst && !done) begin
      check("cmp dp_ce",       bus.dp_ce,       m_ce());
      check("cmp cmd_ready",   bus.cmd_ready,   m_ready());
      check("cmp state",       bus.state_o,     m_mode);
      check("cmp bp_hit",      bus.bp_hit,      m_bp_hit);
      check("cmp dp_pc_reset", bus.dp_pc_reset, m_pcr);
      check("cmp cycle_cnt",   bus.cycle_cnt,   m_cyc);
      check("cmp retired_cnt", bus.retired_cnt, m_ret);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] pc;
  bit          halt_en;
  logic [31:0] halt_pc;

  // Emulated datapath: PC advances by 4 per retire, clears on dp_pc_reset.
  task automatic tick();
    bit ce;
    bit pcr;
    ce  = rst && m_ce();
    pcr = m_pcr;
    @(posedge clk);
    #1;
    if (pcr) pc = '0;
    else if (ce) pc = pc + 32'd4;
    bus.dp_pc        = pc;
    bus.dp_halt_insn = halt_en && (pc == halt_pc);
  endtask

  task automatic cmd(input logic [1:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pc = '0; halt_en = 0; halt_pc = '0;
    bus.cmd_valid = 0; bus.cmd_op = 2'd0; bus.bp_en = 0; bus.bp_addr = '0;
    bus.dp_pc = '0; bus.dp_halt_insn = 0; bus.mem_busy = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state",       bus.state_o, 2'd1);
    check("reset cycle_cnt",   bus.cycle_cnt, 0);
    check("reset retired_cnt", bus.retired_cnt, 0);
    check("reset bp_hit",      bus.bp_hit, 0);
    check("reset dp_pc_reset", bus.dp_pc_reset, 0);
    rst = 1'b1;

    // Free run, 10 cycles.
    repeat (10) tick();
    check("run cycle_cnt",   bus.cycle_cnt, 10);
    check("run retired_cnt", bus.retired_cnt, 10);

    // Three stall cycles.
    bus.mem_busy = 1'b1;
    #1 check("stall dp_ce", bus.dp_ce, 0);
    repeat (3) tick();
    bus.mem_busy = 1'b0;
    #1;
    check("stall cycle_cnt",   bus.cycle_cnt, 13);
    check("stall retired_cnt", bus.retired_cnt, 10);

    // Breakpoint at 0x40 (PC is 0x28 here), then resume from it.
    bus.bp_en = 1'b1; bus.bp_addr = 32'h40;
    repeat (6) tick();
    #1 check("bp dp_ce", bus.dp_ce, 0);
    tick();
    check("bp hit pulse", bus.bp_hit, 1);
    check("bp state",     bus.state_o, 0);
    check("bp retired",   bus.retired_cnt, 16);
    check("bp cycles",    bus.cycle_cnt, 20);
    tick();
    check("bp hit clear", bus.bp_hit, 0);
    cmd(2'd0);
    #1 check("bp resume dp_ce", bus.dp_ce, 1);
    tick();
    check("bp resume retired", bus.retired_cnt, 17);
    tick();
    bus.bp_en = 1'b0;

    // HALT command, then CLR.
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1;
    #1 check("haltcmd dp_ce", bus.dp_ce, 0);
    tick();
    bus.cmd_valid = 1'b0;
    check("haltcmd state",   bus.state_o, 0);
    check("haltcmd retired", bus.retired_cnt, 18);
    check("haltcmd cycles",  bus.cycle_cnt, 23);
    cmd(2'd3);
    check("clr pulse",   bus.dp_pc_reset, 1);
    check("clr cycles",  bus.cycle_cnt, 0);
    check("clr retired", bus.retired_cnt, 0);
    tick();
    check("clr pulse end", bus.dp_pc_reset, 0);

    // HALT instruction at 0x20 (PC restarts at 0).
    halt_en = 1; halt_pc = 32'h20;
    cmd(2'd0);
    repeat (8) tick();
    #1 check("hinsn dp_ce", bus.dp_ce, 1);
    tick();
    check("hinsn state",   bus.state_o, 0);
    check("hinsn ready",   bus.cmd_ready, 1);
    check("hinsn retired", bus.retired_cnt, 9);
    check("hinsn cycles",  bus.cycle_cnt, 9);
    halt_en = 0; bus.dp_halt_insn = 0;

    // Single step with two stall cycles.
    cmd(2'd2);
    bus.mem_busy = 1'b1;
    #1 check("step ready 1", bus.cmd_ready, 0);
    check("step state", bus.state_o, 2);
    tick();
    check("step ready 2", bus.cmd_ready, 0);
    tick();
    bus.mem_busy = 1'b0;
    #1 check("step ready 3", bus.cmd_ready, 0);
    check("step dp_ce", bus.dp_ce, 1);
    tick();
    check("step state end", bus.state_o, 0);
    check("step retired",   bus.retired_cnt, 10);
    check("step cycles",    bus.cycle_cnt, 12);

    // Reset while stalled mid-step.
    cmd(2'd2);
    bus.mem_busy = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst mid-step state",   bus.state_o, 1);
    check("rst mid-step cycles",  bus.cycle_cnt, 0);
    check("rst mid-step retired", bus.retired_cnt, 0);
    check("rst mid-step ready",   bus.cmd_ready, 1);
    tick();
    pc = '0; bus.dp_pc = '0; bus.mem_busy = 1'b0;
    rst = 1'b1;
    repeat (5) tick();
    check("post-rst retired", bus.retired_cnt, 5);
    check("post-rst cycles",  bus.cycle_cnt, 5);

    done = 1'b1;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
